// File: rtl/sinx_sched_pkg.sv
// sinx_sched_pkg: default parameters and FSM state encoding shared by the
// sinx scheduler and its round-robin arbiter.
package sinx_sched_pkg;

    localparam int unsigned NUM_REQ_DEF        = 4;
    localparam int unsigned DATA_W_DEF         = 16;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 64;

    // Scheduler FSM state encoding.
    localparam int unsigned STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_ISSUE = 3'd1;
    localparam logic [STATE_W-1:0] ST_WAIT  = 3'd2;
    localparam logic [STATE_W-1:0] ST_RESP  = 3'd3;
    localparam logic [STATE_W-1:0] ST_DRAIN = 3'd4;

endpackage

// File: rtl/sinx_rr_arbiter.sv
// sinx_rr_arbiter: one-hot round-robin grant; the winner is the first valid
// index strictly after ptr, wrapping from NUM_REQ-1 back to 0.
module sinx_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         valid,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant
);

    localparam int unsigned IDW = $clog2(NUM_REQ);

    logic           found;
    logic [IDW-1:0] idx;

    // Scan requesters starting just after the last granted one.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = IDW'((32'(ptr) + k) % NUM_REQ);
            if (!found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sinx_scheduler.sv
// sinx_scheduler: shares one iterative sinx core among NUM_REQ requesters.
// One job at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// Optional watchdog on WAIT enabled by defining SINX_SCHED_TIMEOUT_EN; an
// expired job returns an error response and then DRAINs the late core done.
module sinx_scheduler
    import sinx_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ        = NUM_REQ_DEF,
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_x_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic [$clog2(NUM_REQ)-1:0]  rsp_id_o,
    output logic [DATA_W-1:0]           rsp_y_o,
    output logic                        rsp_err_o,
    output logic                        core_start_o,
    output logic [DATA_W-1:0]           core_x_o,
    input  logic                        core_done_i,
    input  logic [DATA_W-1:0]           core_y_i,
    output logic                        busy_o
);

    localparam int unsigned IDW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("sinx_scheduler: parameter out of range");
    end

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_next;
    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     gidx;
    logic [IDW-1:0]     sel;
    logic [NUM_REQ-1:0] grant;
    logic [DATA_W-1:0]  x_slice [NUM_REQ];
    logic [DATA_W-1:0]  gx;
    logic               accept;
    logic               timed_out;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_xslice
        assign x_slice[g] = req_x_i[g*DATA_W +: DATA_W];
    end

    sinx_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .valid (req_valid_i),
        .ptr   (ptr),
        .grant (grant)
    );

    // Grants are only offered while idle; a handshake is any granted valid.
    assign req_ready_o = (state == ST_IDLE) ? grant : '0;
    assign accept      = (state == ST_IDLE) && (|grant);
    assign gx          = x_slice[gidx];

    // Encode the one-hot grant as a requester index.
    always_comb begin
        gidx = '0;
        sel  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            sel = IDW'(i);
            if (grant[sel]) begin
                gidx = sel;
            end
        end
    end

    // Next-state logic; done is only looked at in WAIT and DRAIN so a stale
    // done level from the previous job is ignored during ISSUE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  if (core_done_i || timed_out) state_next = ST_RESP;
            ST_RESP:  if (rsp_ready_i) state_next = rsp_err_o ? ST_DRAIN : ST_IDLE;
            ST_DRAIN: if (core_done_i) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State, arbitration pointer, job registers and registered status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            ptr          <= IDW'(NUM_REQ - 1);
            core_x_o     <= '0;
            rsp_id_o     <= '0;
            rsp_y_o      <= '0;
            core_start_o <= 1'b0;
            rsp_valid_o  <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            state        <= state_next;
            core_start_o <= (state_next == ST_ISSUE);
            rsp_valid_o  <= (state_next == ST_RESP);
            busy_o       <= (state_next != ST_IDLE);
            if (accept) begin
                ptr      <= gidx;
                rsp_id_o <= gidx;
                core_x_o <= gx;
            end
            if (state == ST_WAIT) begin
                if (core_done_i) begin
                    rsp_y_o <= core_y_i;
                end else if (timed_out) begin
                    rsp_y_o <= '0;
                end
            end
        end
    end

`ifdef SINX_SCHED_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             err_q;

    assign timed_out = (state == ST_WAIT) && !core_done_i &&
                       (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign rsp_err_o = err_q;

    // Watchdog over WAIT cycles and the error flag reported with the response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == ST_WAIT) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
                if (core_done_i) begin
                    err_q <= 1'b0;
                end else if (timed_out) begin
                    err_q <= 1'b1;
                end
            end else begin
                tmo_cnt <= '0;
            end
        end
    end
`else
    assign timed_out = 1'b0;
    assign rsp_err_o = 1'b0;
`endif

endmodule

// File: doc/sinx_scheduler.md
SINX_SCHEDULER -- requirements
Module: sinx_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one sinx core (range 2..8).
REQ-002 Parameter DATA_W, default 16, operand/result width.
REQ-003 Parameter TIMEOUT_CYCLES, default 64, watchdog limit in clock cycles (used only with SINX_SCHED_TIMEOUT_EN).
REQ-004 clk_i  input  1  single clock, all logic on rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 req_valid_i  input  NUM_REQ  per-requester operand valid.
REQ-007 req_x_i  input  NUM_REQ*DATA_W  per-requester operand x; slice i = bits [i*DATA_W +: DATA_W].
REQ-008 req_ready_o  output  NUM_REQ  per-requester accept, at most one bit high.
REQ-009 rsp_valid_o  output  1  result valid.
REQ-010 rsp_ready_i  input  1  result consumer ready.
REQ-011 rsp_id_o  output  $clog2(NUM_REQ)  index of requester owning the result.
REQ-012 rsp_y_o  output  DATA_W  sin(x) result from core.
REQ-013 rsp_err_o  output  1  result invalid (timeout).
REQ-014 core_start_o  output  1  one-cycle start pulse to sinx core.
REQ-015 core_x_o  output  DATA_W  operand to core, held stable for the whole job.
REQ-016 core_done_i  input  1  core done level (stays high until next start).
REQ-017 core_y_i  input  DATA_W  core sum register value.
REQ-018 busy_o  output  1  high in every state except IDLE.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT, RESP, DRAIN.
REQ-020 IDLE: if any req_valid_i, grant winner g combinationally (req_ready_o[g]=1); on handshake latch x, id=g, go ISSUE; else stay.
REQ-021 Arbitration SHALL be round-robin: winner = first valid index strictly after last granted index, wrapping NUM_REQ-1 -> 0.
REQ-022 Pointer SHALL update only on an accepted handshake; no grant while req_valid_i is all zero.
REQ-023 ISSUE: core_start_o=1 for exactly this one cycle; core_done_i ignored in this cycle; next state WAIT.
REQ-024 WAIT: on core_done_i=1 latch core_y_i into rsp_y_o, rsp_err_o=0, go RESP.
REQ-025 RESP: rsp_valid_o=1 with rsp_id_o/rsp_y_o/rsp_err_o stable until rsp_valid_o & rsp_ready_i; then go IDLE (or DRAIN after a timeout).
REQ-026 New requests SHALL be accepted only in IDLE; a response handshake and a new request in the same cycle yield one IDLE bubble cycle.
REQ-027 core_x_o SHALL hold the latched operand from ISSUE until the next accepted request.
REQ-028 Requests are not queued; a requester drops or holds valid as it wishes, ungranted valid is not lost state.

Reset
REQ-029 rst_i=1 at a clock edge SHALL force IDLE, pointer to NUM_REQ-1 (requester 0 wins first), all outputs and latched registers to 0.
REQ-030 Reset mid-job SHALL abandon the job without a response; integration SHALL reset the core from the same source (rstn = ~rst_i).

Configuration
REQ-031 With SINX_SCHED_TIMEOUT_EN defined: WAIT counts cycles; reaching TIMEOUT_CYCLES without done goes RESP with rsp_err_o=1, rsp_y_o=0, then DRAIN waits for core_done_i before IDLE.
REQ-032 Without SINX_SCHED_TIMEOUT_EN: no counter, DRAIN unreachable, rsp_err_o tied 0, WAIT indefinite.

Structure
REQ-033 Package sinx_sched_pkg SHALL hold the state enum and default DATA_W/NUM_REQ/TIMEOUT_CYCLES constants.
REQ-034 Round-robin grant logic SHALL be sub-module sinx_rr_arbiter (inputs valid vector, pointer; output one-hot grant).

Verification
REQ-035 Single req: req 2 valid, x=0x4000 -> req_ready_o=0b0100, one start pulse, rsp_id_o=2, rsp_y_o equals core result, rsp_err_o=0.
REQ-036 Contention: all 4 valid from reset -> grant order 0,1,2,3,0; exactly one start per job.
REQ-037 Backpressure: rsp_ready_i low 10 cycles -> rsp_valid_o and data stable, no new grant, no start.
REQ-038 Stale done: done_i high during ISSUE from previous job -> ignored, response only after fresh done.
REQ-039 Timeout (macro on, TIMEOUT_CYCLES=8, core stalled) -> rsp_err_o=1, rsp_y_o=0, DRAIN until done, then IDLE.
REQ-040 Reset mid-WAIT -> next cycle IDLE, busy_o=0, no rsp_valid_o, next grant goes to requester 0.
